// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Holds the two-state FSM encoding, the per-requester statistics counter width
// and the helper that sizes requester index fields.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // A single requester still needs a one-bit index field, so never return zero
  function automatic int calc_idx_w(input int n);
    if (n > 1) return $clog2(n);
    else       return 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting at i_ptr, wrapping from the top index back
// to 0, and reports the first active requester as a one-hot grant plus index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = calc_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  function automatic int wrapIdx(input int ptr, input int ofs);
    return (ptr + ofs) % N_REQ;
  endfunction

  // First requester at or after the pointer wins; later candidates are masked by o_found
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_found && i_req[wrapIdx(int'(i_ptr), i)]) begin
        o_found                           = 1'b1;
        o_idx                             = IDX_W'(wrapIdx(int'(i_ptr), i));
        o_grant[wrapIdx(int'(i_ptr), i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-oriented write arbiter in front of a FIFO.
// Idle arbitration grants one requester round-robin when the FIFO can take a
// whole burst; the burst then streams combinationally into the FIFO until the
// requester marks last, the beat limit is hit, or its valid drops.
// Optional feature: define FIFO_ARB_STAT_EN to add o_grant_cnt, one saturating
// 16-bit burst-start counter per requester.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4,
  parameter int REMAIN_W  = 9,
  localparam int IDX_W    = calc_idx_w(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic                   i_fifo_full,
  input  logic [REMAIN_W-1:0]    i_fifo_remain,
  output logic                   o_fifo_wen,
  output logic [WIDTH-1:0]       o_fifo_wdata,
  output logic [IDX_W-1:0]       o_fifo_wid,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy
`ifdef FIFO_ARB_STAT_EN
  ,
  output logic [N_REQ*STAT_W-1:0] o_grant_cnt
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t           r_state, w_stateNext;
  logic [N_REQ-1:0] r_grant, w_grantNext;
  logic [IDX_W-1:0] r_gIdx, w_gIdxNext;
  logic [IDX_W-1:0] r_rrPtr, w_rrPtrNext;
  logic [CNT_W-1:0] r_beatCnt, w_beatCntNext;

  logic [N_REQ-1:0] w_pickGrant;
  logic [IDX_W-1:0] w_pickIdx;
  logic             w_pickFound;

  logic w_arbFire, w_inBurst, w_validG, w_lastG, w_accept, w_burstEnd;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickGrant),
    .o_idx   (w_pickIdx),
    .o_found (w_pickFound)
  );

  // A burst is only started when the FIFO is guaranteed room for all of it
  assign w_arbFire  = w_pickFound & ~i_fifo_full & (i_fifo_remain >= REMAIN_W'(BURST_LEN));
  assign w_inBurst  = (r_state == ST_BURST);
  assign w_validG   = i_req_valid[r_gIdx];
  assign w_lastG    = i_req_last[r_gIdx];
  assign w_accept   = w_inBurst & w_validG & ~i_fifo_full;
  assign w_burstEnd = w_inBurst &
                      (~w_validG |
                       (w_accept & (w_lastG | ((r_beatCnt + 1'b1) == CNT_W'(BURST_LEN)))));

  assign o_grant = r_grant;
  assign o_busy  = w_inBurst;

  // State, grant, owner, pointer and beat count registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_gIdx    <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_gIdx    <= w_gIdxNext;
      r_rrPtr   <= w_rrPtrNext;
      r_beatCnt <= w_beatCntNext;
    end
  end

  // Next-state decode plus the combinational FIFO push path of the granted requester
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_gIdxNext    = r_gIdx;
    w_rrPtrNext   = r_rrPtr;
    w_beatCntNext = r_beatCnt;
    o_req_ready   = '0;
    o_fifo_wen    = 1'b0;
    o_fifo_wdata  = '0;
    o_fifo_wid    = '0;
    case (r_state)
      ST_IDLE: begin
        w_grantNext = '0;
        if (w_arbFire) begin
          w_stateNext   = ST_BURST;
          w_grantNext   = w_pickGrant;
          w_gIdxNext    = w_pickIdx;
          w_beatCntNext = '0;
        end
      end
      ST_BURST: begin
        o_req_ready[r_gIdx] = ~i_fifo_full;
        o_fifo_wen          = w_validG & ~i_fifo_full;
        o_fifo_wdata        = i_req_data[int'(r_gIdx)*WIDTH +: WIDTH];
        o_fifo_wid          = r_gIdx;
        if (w_burstEnd) begin
          w_stateNext   = ST_IDLE;
          w_grantNext   = '0;
          w_beatCntNext = '0;
          w_rrPtrNext   = (int'(r_gIdx) == N_REQ - 1) ? '0 : r_gIdx + 1'b1;
        end else if (w_accept) begin
          w_beatCntNext = r_beatCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_grantNext = '0;
      end
    endcase
  end

`ifdef FIFO_ARB_STAT_EN
  logic [STAT_W-1:0] r_grantCnt [N_REQ];

  // Count burst starts per requester, sticking at all-ones instead of wrapping
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < N_REQ; k++) r_grantCnt[k] <= '0;
    end else if ((r_state == ST_IDLE) && w_arbFire) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (w_pickGrant[k] && (r_grantCnt[k] != '1)) r_grantCnt[k] <= r_grantCnt[k] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_statOut
    assign o_grant_cnt[g*STAT_W +: STAT_W] = r_grantCnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (default parameters).
// A cycle-level behavioural model of the arbitration rules predicts every
// output; directed scenarios add concrete push/grant-order expectations and a
// randomized phase stresses valid drops, full stalls, remain gating and resets.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int RW = 9;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   v = '0;
  logic [N*W-1:0] d = '0;
  logic [N-1:0]   l = '0;
  logic           f = 1'b0;
  logic [RW-1:0]  rem = '0;

  logic [N-1:0]   readyOut;
  logic           wenOut;
  logic [W-1:0]   wdataOut;
  logic [1:0]     widOut;
  logic [N-1:0]   grantOut;
  logic           busyOut;
`ifdef FIFO_ARB_STAT_EN
  logic [N*16-1:0] grantCntOut;
`endif

  // Stimulus sources: each requester streams srcBase+beatNumber, last every srcLast beats
  bit          srcOn   [N];
  int          srcBeat [N];
  logic [7:0]  srcBase [N];
  int          srcLast;
  logic        rstnIn;
  logic        fullIn;
  logic [RW-1:0] remIn;

  // Behavioural model state
  bit mBusy;
  int mOwner, mBeats, mPtr;
  int mStat [N];

  // Observation logs
  logic [W-1:0] pushData[$];
  int           pushWid[$];
  int           grantOrder[$];
  logic [N-1:0] prevGrant = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .N_REQ     (N),
    .BURST_LEN (BL),
    .REMAIN_W  (RW)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_req_valid   (v),
    .i_req_data    (d),
    .i_req_last    (l),
    .o_req_ready   (readyOut),
    .i_fifo_full   (f),
    .i_fifo_remain (rem),
    .o_fifo_wen    (wenOut),
    .o_fifo_wdata  (wdataOut),
    .o_fifo_wid    (widOut),
    .o_grant       (grantOut),
    .o_busy        (busyOut)
`ifdef FIFO_ARB_STAT_EN
    ,
    .o_grant_cnt   (grantCntOut)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    pushData.delete();
    pushWid.delete();
    grantOrder.delete();
  endtask

  // One clock cycle: drive at the falling edge, check just after, then advance the model
  task automatic applyStimulus();
    logic [N-1:0] expGrant, expReady;
    logic         expWen, expBusy;
    logic [W-1:0] expData;
    logic [1:0]   expWid;
    bit           ended;
    int           winner;
    @(negedge clk);
    rstn = rstnIn;
    for (int k = 0; k < N; k++) begin
      v[k]       = srcOn[k];
      d[k*W +: W] = srcBase[k] + 8'(srcBeat[k]);
      l[k]       = (srcLast != 0) && ((srcBeat[k] % srcLast) == srcLast - 1);
    end
    f   = fullIn;
    rem = remIn;
    #1;
    if (!rstnIn) begin
      mBusy  = 1'b0;
      mPtr   = 0;
      mBeats = 0;
      for (int k = 0; k < N; k++) mStat[k] = 0;
    end
    expGrant = '0; expReady = '0; expWen = 1'b0; expData = '0; expWid = '0;
    expBusy  = mBusy;
    if (mBusy) begin
      expGrant[mOwner] = 1'b1;
      expReady[mOwner] = !f;
      expWen           = v[mOwner] && !f;
      expData          = d[mOwner*W +: W];
      expWid           = 2'(mOwner);
    end
    checkOutput("grant", grantOut, expGrant);
    checkOutput("busy",  busyOut,  expBusy);
    checkOutput("ready", readyOut, expReady);
    checkOutput("wen",   wenOut,   expWen);
    checkOutput("wdata", wdataOut, expData);
    checkOutput("wid",   widOut,   expWid);
`ifdef FIFO_ARB_STAT_EN
    for (int k = 0; k < N; k++) checkOutput("grant_cnt", grantCntOut[k*16 +: 16], 64'(mStat[k]));
`endif
    if (wenOut === 1'b1) begin
      pushData.push_back(wdataOut);
      pushWid.push_back(int'(widOut));
    end
    if (grantOut != '0 && prevGrant == '0) begin
      for (int k = 0; k < N; k++) if (grantOut[k]) grantOrder.push_back(k);
    end
    prevGrant = grantOut;
    if (rstnIn) begin
      if (!mBusy) begin
        if (v != '0 && !f && rem >= RW'(BL)) begin
          winner = -1;
          for (int k = 0; k < N; k++) begin
            if (winner < 0 && v[(mPtr + k) % N]) winner = (mPtr + k) % N;
          end
          mBusy  = 1'b1;
          mOwner = winner;
          mBeats = 0;
          if (mStat[winner] < 65535) mStat[winner]++;
        end
      end else begin
        ended = 1'b0;
        if (!v[mOwner]) ended = 1'b1;
        else if (!f) begin
          srcBeat[mOwner]++;
          mBeats++;
          if (l[mOwner] || mBeats == BL) ended = 1'b1;
        end
        if (ended) begin
          mBusy = 1'b0;
          mPtr  = (mOwner + 1) % N;
        end
      end
    end
  endtask

  initial begin
    rstnIn  = 1'b0;
    fullIn  = 1'b0;
    remIn   = 9'd16;
    srcLast = 4;
    mBusy = 1'b0; mOwner = 0; mBeats = 0; mPtr = 0;
    for (int k = 0; k < N; k++) begin
      srcOn[k] = 1'b0; srcBeat[k] = 0; srcBase[k] = '0; mStat[k] = 0;
    end

    // Reset state
    repeat (2) applyStimulus();
    rstnIn = 1'b1;
    applyStimulus();

    // Single requester 2 streams 0x11..0x14
    $display("[TB] single requester burst");
    clearLogs();
    srcBase[2] = 8'h11;
    srcOn[2]   = 1'b1;
    repeat (5) applyStimulus();
    srcOn[2] = 1'b0;
    applyStimulus();
    checkOutput("single_push_count", pushData.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("single_data", pushData[i], 64'(8'h11 + i));
      checkOutput("single_wid",  pushWid[i], 2);
    end
    checkOutput("single_grant_cnt", grantOrder.size(), 1);
    checkOutput("single_grant_idx", grantOrder[0], 2);

    // Reset asserted mid-burst
    $display("[TB] reset mid-burst");
    srcBase[0] = 8'h30;
    srcOn[0]   = 1'b1;
    repeat (3) applyStimulus();
    rstnIn = 1'b0;
    applyStimulus();
    checkOutput("rst_wen",   wenOut,   0);
    checkOutput("rst_grant", grantOut, 0);
    checkOutput("rst_busy",  busyOut,  0);
    checkOutput("rst_ready", readyOut, 0);
    applyStimulus();
    rstnIn   = 1'b1;
    srcOn[0] = 1'b0;
    applyStimulus();

    // Fairness: all four valid from pointer 0
    $display("[TB] round-robin fairness");
    clearLogs();
    for (int k = 0; k < N; k++) begin
      srcBeat[k] = 0;
      srcBase[k] = 8'(k * 8'h40);
      srcOn[k]   = 1'b1;
    end
    repeat (25) applyStimulus();
    for (int k = 0; k < N; k++) srcOn[k] = 1'b0;
    applyStimulus();
    checkOutput("fair_bursts", grantOrder.size(), 5);
    checkOutput("fair_order0", grantOrder[0], 0);
    checkOutput("fair_order1", grantOrder[1], 1);
    checkOutput("fair_order2", grantOrder[2], 2);
    checkOutput("fair_order3", grantOrder[3], 3);
    checkOutput("fair_order4", grantOrder[4], 0);
    checkOutput("fair_pushes", pushData.size(), 20);

    // FIFO full for three cycles after beat 2
    $display("[TB] full stall");
    clearLogs();
    srcBeat[3] = 0;
    srcBase[3] = 8'hA0;
    srcOn[3]   = 1'b1;
    repeat (3) applyStimulus();
    fullIn = 1'b1;
    repeat (3) begin
      applyStimulus();
      checkOutput("stall_wen",   wenOut,   0);
      checkOutput("stall_ready", readyOut, 0);
    end
    fullIn = 1'b0;
    repeat (2) applyStimulus();
    srcOn[3] = 1'b0;
    applyStimulus();
    checkOutput("stall_push_count", pushData.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_data", pushData[i], 64'(8'hA0 + i));
      checkOutput("stall_wid",  pushWid[i], 3);
    end

    // Remain gating: 3 free slots blocks a 4-beat burst, 4 allows it
    $display("[TB] remain gating");
    clearLogs();
    remIn    = 9'd3;
    srcOn[0] = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("gate_busy",   busyOut, 0);
    checkOutput("gate_grants", grantOrder.size(), 0);
    remIn = 9'd4;
    applyStimulus();
    applyStimulus();
    checkOutput("gate_grant", grantOut, 4'b0001);
    srcOn[0] = 1'b0;
    repeat (2) applyStimulus();
    remIn = 9'd16;

    // Early end when valid drops, then pointer advance
    $display("[TB] early end");
    clearLogs();
    srcOn[1] = 1'b1;
    repeat (2) applyStimulus();
    srcOn[1] = 1'b0;
    applyStimulus();
    srcOn[0] = 1'b1;
    srcOn[2] = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("early_grants", grantOrder.size(), 2);
    checkOutput("early_first",  grantOrder[0], 1);
    checkOutput("early_next",   grantOrder[1], 2);
    srcOn[0] = 1'b0;
    srcOn[2] = 1'b0;
    repeat (2) applyStimulus();

    // Randomized traffic
    $display("[TB] randomized traffic");
    srcLast = 3;
    for (int k = 0; k < N; k++) srcBase[k] = 8'($urandom_range(0, 255));
    repeat (400) begin
      for (int k = 0; k < N; k++) srcOn[k] = ($urandom_range(0, 3) != 0);
      fullIn = ($urandom_range(0, 4) == 0);
      remIn  = 9'($urandom_range(0, 8));
      rstnIn = ($urandom_range(0, 99) != 0);
      applyStimulus();
    end
    rstnIn = 1'b1;
    for (int k = 0; k < N; k++) srcOn[k] = 1'b0;
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be WIDTH (default 8, data bits per beat), N_REQ (default 4, requester count, >=2), BURST_LEN (default 4, max beats per grant, >=1), REMAIN_W (default 9, width of FIFO free-slot count).
REQ-002 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 i_rstn  in  1  asynchronous active-low reset.
REQ-004 i_req_valid  in  N_REQ  per-requester beat valid.
REQ-005 i_req_data  in  N_REQ*WIDTH  requester k at bits [k*WIDTH +: WIDTH].
REQ-006 i_req_last  in  N_REQ  marks the final beat of a requester's burst.
REQ-007 o_req_ready  out  N_REQ  per-requester beat accept.
REQ-008 i_fifo_full  in  1  FIFO write-side full flag.
REQ-009 i_fifo_remain  in  REMAIN_W  FIFO free slots.
REQ-010 o_fifo_wen  out  1  FIFO push strobe.
REQ-011 o_fifo_wdata  out  WIDTH  FIFO push data.
REQ-012 o_fifo_wid  out  IDX_W  source index of the pushed beat; IDX_W = max(1, clog2(N_REQ)).
REQ-013 o_grant  out  N_REQ  one-hot registered grant; all-zero when idle.
REQ-014 o_busy  out  1  high while in ST_BURST.

Function
REQ-015 The FSM SHALL have two states: ST_IDLE and ST_BURST.
REQ-016 ST_IDLE arbitration SHALL fire when any i_req_valid bit is high, i_fifo_full=0 and i_fifo_remain >= BURST_LEN.
- On fire: round-robin search starting at rr_ptr, wrapping N_REQ-1 -> 0.
- The winner's o_grant bit SHALL be registered and the FSM SHALL enter ST_BURST on the next edge.
REQ-017 While the arbitration condition is false, ST_IDLE SHALL hold, with o_grant=0 and no push.
REQ-018 In ST_BURST, with granted index g:
- o_req_ready[g] = ~i_fifo_full; every other ready bit = 0.
- o_fifo_wen = i_req_valid[g] & ~i_fifo_full, combinational (zero added latency).
- o_fifo_wdata = requester g data; o_fifo_wid = g.
REQ-019 A beat counter SHALL count accepted beats in ST_BURST, reset to 0 on entry.
REQ-020 The burst SHALL end on the first of:
- an accepted beat with i_req_last[g]=1;
- the accepted beat that makes the count equal BURST_LEN;
- a cycle in which i_req_valid[g]=0.
REQ-021 At burst end:
- next state ST_IDLE, o_grant cleared;
- rr_ptr = (g+1) mod N_REQ.
- The cycle after a burst is always ST_IDLE, so at least one idle cycle separates grants.
REQ-022 If i_fifo_full rises mid-burst, the arbiter SHALL stall: no push, counter held, state held.
REQ-023 When not in ST_BURST, o_fifo_wen and o_req_ready SHALL be 0 and o_fifo_wdata SHALL be 0.

Reset
REQ-024 While i_rstn=0:
- state = ST_IDLE, rr_ptr = 0, beat counter = 0;
- o_grant, o_req_ready, o_fifo_wen, o_fifo_wdata, o_fifo_wid, o_busy all 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately; no push occurs in the reset cycle.

Configuration
REQ-026 With FIFO_ARB_STAT_EN defined:
- add output o_grant_cnt (N_REQ*16 bits), one 16-bit saturating count per requester;
- each count increments at every burst start for that requester and clears on reset.
- Without the macro, the port and its logic SHALL be absent.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold:
- the state enum (ST_IDLE, ST_BURST);
- the stat counter width constant (16);
- a function computing IDX_W from N_REQ.
REQ-028 The round-robin picker SHALL be the sub-module rr_pick:
- inputs: request vector and rr_ptr;
- outputs: one-hot grant, winner index, found flag;
- purely combinational.

Verification
REQ-029 Single requester: N_REQ=4, BURST_LEN=4, requester 2 streams 4 beats (0x11-0x14), last on beat 4, remain=16 -> grant in the cycle after valid; 4 consecutive pushes with wid=2; then idle.
REQ-030 Fairness: all four valid continuously, rr_ptr=0 -> bursts granted in order 0,1,2,3,0; each burst is 4 beats with one idle cycle between bursts.
REQ-031 Full stall: i_fifo_full pulses high for 3 cycles after beat 2 -> no push and ready low for those 3 cycles; beats 3-4 complete afterwards with data intact.
REQ-032 Remain gating: remain=3, BURST_LEN=4, requester valid -> no grant; remain rises to 4 -> grant on the next edge.
REQ-033 Early end and reset: requester drops valid after 1 beat -> ST_IDLE next cycle and rr_ptr advances. Separately, i_rstn asserted mid-burst -> all outputs 0 immediately, rr_ptr=0.
REQ-034 With FIFO_ARB_STAT_EN defined: 3 bursts from requester 1 -> o_grant_cnt slice 1 = 3; a preloaded count of 0xFFFF holds at 0xFFFF.
